// File: rtl/mux_sel_pipe.sv
// N-way WIDTH-bit registered selector with a one-deep valid/ready output stage.
// Define MUX_SCAN_EN to compile in scan mode (internal counter stepping through every channel).
module mux_sel_pipe #(
    parameter int WIDTH = 16,
    parameter int N     = 16,
    parameter int SEL_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*WIDTH-1:0] din,
    input  logic [SEL_W-1:0]   sel,
    input  logic               mode,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   dout,
    output logic [SEL_W-1:0]   out_sel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic               sel_err,
    output logic [SEL_W-1:0]   scan_idx
);

    typedef enum logic {EMPTY, FULL} state_t;

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N - 1);
    localparam logic [SEL_W:0]   N_EXT    = (SEL_W + 1)'(N);

    state_t             state_q;
    state_t             state_d;
    logic               in_fire;
    logic               out_fire;
    logic               scan_mode;
    logic [SEL_W-1:0]   scan_cur;
    logic [SEL_W-1:0]   idx;
    logic [WIDTH-1:0]   sel_data;
    logic               idx_err;
    logic [WIDTH-1:0]   dout_q;
    logic [SEL_W-1:0]   out_sel_q;
    logic               sel_err_q;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (in_fire) state_d = FULL;
            FULL:    if (out_fire && !in_fire) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        out_valid = (state_q == FULL);
        in_ready  = !rst && (!out_valid || out_ready);
    end

`ifdef MUX_SCAN_EN
    logic [SEL_W-1:0] scan_q;
    logic             out_last_q;

    assign scan_mode = mode;
    assign scan_cur  = scan_q;
    assign scan_idx  = scan_q;
    assign out_last  = out_last_q;

    // Counter only runs while scanning; any direct-mode cycle restarts it at channel 0.
    always_ff @(posedge clk) begin
        if (rst || !scan_mode) begin
            scan_q <= '0;
        end else if (in_fire) begin
            scan_q <= (scan_q == LAST_IDX) ? '0 : scan_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_last_q <= 1'b0;
        end else if (in_fire) begin
            out_last_q <= scan_mode && (idx == LAST_IDX);
        end
    end
`else
    logic unused_mode;

    assign unused_mode = mode;
    assign scan_mode   = 1'b0;
    assign scan_cur    = '0;
    assign scan_idx    = '0;
    assign out_last    = 1'b0;
`endif

    assign idx     = scan_mode ? scan_cur : sel;
    assign idx_err = ({1'b0, idx} >= N_EXT);

    // An index with no matching channel falls through to zero data.
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < N; k++) begin
            if (idx == SEL_W'(k)) begin
                sel_data = din[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q    <= '0;
            out_sel_q <= '0;
            sel_err_q <= 1'b0;
        end else if (in_fire) begin
            dout_q    <= sel_data;
            out_sel_q <= idx;
            sel_err_q <= idx_err;
        end
    end

    assign dout    = dout_q;
    assign out_sel = out_sel_q;
    assign sel_err = sel_err_q;

endmodule

// File: tb/tb_mux_sel_pipe.sv
// Scoreboard bench for mux_sel_pipe: a 16-channel instance plus a 10-channel one for out-of-range selects.
module tb_mux_sel_pipe;

    typedef struct {
        logic [15:0] dout;
        logic [3:0]  sel;
        logic        err;
        logic        last;
    } beat_t;

`ifdef MUX_SCAN_EN
    localparam bit SCAN_ON = 1'b1;
`else
    localparam bit SCAN_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [255:0] din;
    logic [3:0]   sel = '0;
    logic         mode = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [15:0]  dout;
    logic [3:0]   out_sel;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         out_last;
    logic         sel_err;
    logic [3:0]   scan_idx;

    logic [159:0] din_b;
    logic [3:0]   sel_b = '0;
    logic         in_valid_b = 1'b0;
    logic         in_ready_b;
    logic [15:0]  dout_b;
    logic [3:0]   out_sel_b;
    logic         out_valid_b;
    logic         out_ready_b = 1'b1;
    logic         out_last_b;
    logic         sel_err_b;
    logic [3:0]   scan_idx_b;

    int    checks   = 0;
    int    failures = 0;
    beat_t sb_q[$];
    logic [3:0] model_scan = '0;

    always #5 clk = ~clk;

    mux_sel_pipe #(.WIDTH(16), .N(16), .SEL_W(4)) dut (
        .clk(clk), .rst(rst), .din(din), .sel(sel), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .dout(dout), .out_sel(out_sel),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .sel_err(sel_err), .scan_idx(scan_idx)
    );

    mux_sel_pipe #(.WIDTH(16), .N(10), .SEL_W(4)) dut_b (
        .clk(clk), .rst(rst), .din(din_b), .sel(sel_b), .mode(1'b0),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .dout(dout_b), .out_sel(out_sel_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_last(out_last_b),
        .sel_err(sel_err_b), .scan_idx(scan_idx_b)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // One cycle on the 16-channel instance: drive, check the held beat, update the model.
    task automatic applyStimulus(input logic v, input logic [3:0] s, input logic m, input logic ordy);
        logic       exp_ready;
        logic       eff;
        logic       acc;
        logic [3:0] idx;
        beat_t      b;
        @(negedge clk);
        in_valid  = v;
        sel       = s;
        mode      = m;
        out_ready = ordy;
        #1;
        exp_ready = (sb_q.size() == 0) || ordy;
        checkOutput("in_ready", 32'(in_ready), 32'(exp_ready));
        checkOutput("out_valid", 32'(out_valid), 32'(sb_q.size() != 0));
        checkOutput("scan_idx", 32'(scan_idx), 32'(model_scan));
        if (sb_q.size() != 0) begin
            checkOutput("dout", 32'(dout), 32'(sb_q[0].dout));
            checkOutput("out_sel", 32'(out_sel), 32'(sb_q[0].sel));
            checkOutput("sel_err", 32'(sel_err), 32'(sb_q[0].err));
            checkOutput("out_last", 32'(out_last), 32'(sb_q[0].last));
            if (ordy) void'(sb_q.pop_front());
        end
        eff = SCAN_ON && m;
        acc = v && exp_ready;
        if (acc) begin
            idx    = eff ? model_scan : s;
            b.dout = 16'(idx);
            b.sel  = idx;
            b.err  = 1'b0;
            b.last = eff && (idx == 4'd15);
            sb_q.push_back(b);
        end
        if (!eff) model_scan = '0;
        else if (acc) model_scan = (model_scan == 4'd15) ? 4'd0 : model_scan + 4'd1;
    endtask

    task automatic resetDut();
        @(negedge clk);
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_valid_b = 1'b0;
        out_ready  = 1'b0;
        #1;
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        #1;
        checkOutput("rst_dout", 32'(dout), 32'd0);
        checkOutput("rst_out_sel", 32'(out_sel), 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_last", 32'(out_last), 32'd0);
        checkOutput("rst_sel_err", 32'(sel_err), 32'd0);
        checkOutput("rst_scan_idx", 32'(scan_idx), 32'd0);
        checkOutput("rst_b_valid", 32'(out_valid_b), 32'd0);
        rst = 1'b0;
        sb_q.delete();
        model_scan = '0;
    endtask

    task automatic oorBeat(input logic [3:0] s, input logic [15:0] exp_dout, input logic exp_err);
        @(negedge clk);
        in_valid_b = 1'b1;
        sel_b      = s;
        #1;
        checkOutput("b_in_ready", 32'(in_ready_b), 32'd1);
        @(negedge clk);
        in_valid_b = 1'b0;
        #1;
        checkOutput("b_out_valid", 32'(out_valid_b), 32'd1);
        checkOutput("b_dout", 32'(dout_b), 32'(exp_dout));
        checkOutput("b_sel_err", 32'(sel_err_b), 32'(exp_err));
        checkOutput("b_out_sel", 32'(out_sel_b), 32'(s));
        checkOutput("b_out_last", 32'(out_last_b), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        for (int k = 0; k < 16; k++) din[k*16 +: 16] = 16'(k);
        for (int k = 0; k < 10; k++) din_b[k*16 +: 16] = 16'(k);
        repeat (2) @(posedge clk);
        resetDut();

        // Direct sweep, no bubbles
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 4'(i), 1'b0, 1'b1);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);

        // Backpressure: 5 held while 9 waits
        applyStimulus(1'b1, 4'd5, 1'b0, 1'b1);
        repeat (3) applyStimulus(1'b1, 4'd9, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd9, 1'b0, 1'b1);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);

        // Scan wrap (direct sel=3 when scan is compiled out)
        for (int i = 0; i < 18; i++) applyStimulus(1'b1, 4'd3, 1'b1, 1'b1);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);

        // Reset mid-scan, then scan restarts at channel 0
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 4'd3, 1'b1, 1'b1);
        resetDut();
        applyStimulus(1'b1, 4'd3, 1'b1, 1'b1);
        applyStimulus(1'b1, 4'd3, 1'b1, 1'b1);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b1);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);

        // Out-of-range select on the 10-channel instance
        oorBeat(4'd12, 16'd0, 1'b1);
        oorBeat(4'd9, 16'd9, 1'b0);
        oorBeat(4'd15, 16'd0, 1'b1);
        oorBeat(4'd0, 16'd0, 1'b0);

        // Mixed traffic with random backpressure and mode changes
        for (int i = 0; i < 60; i++)
            applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        repeat (2) applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
